sr_latch_sync: RTL and testbench
================================

SR_LATCH_SYNC -- requirements
Module: sr_latch_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 0; number of input synchronizer flops on S and R (0..3).
REQ-002 SHALL have parameter FORBID_EXIT_Q, default 0; Q value forced when leaving the forbidden state directly to hold.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 S  input  1  set request, active-low.
REQ-007 R  input  1  reset request, active-low.
REQ-008 Q  output  1  latch state.
REQ-009 Qbar  output  1  complementary output; equals ~Q except in forbidden state.
REQ-010 forbidden  output  1  high while S=0 and R=0 is in effect.
REQ-011 forbid_exit  output  1  one-cycle pulse on a direct forbidden-to-hold transition.

Function
REQ-012 SHALL pass S and R through SYNC_STAGES flops before evaluation; when SYNC_STAGES=0 the raw inputs SHALL be sampled directly.
REQ-013 SHALL implement states Q0, Q1 and FORBID, with a registered state update once per rising edge.
REQ-014 Effective (S,R)=(1,1) hold: state unchanged.
REQ-015 (0,1) set: next state Q1; Q=1, Qbar=0.
REQ-016 (1,0) reset: next state Q0; Q=0, Qbar=1.
REQ-017 (0,0) forbidden: next state FORBID; Q=1, Qbar=1, forbidden=1.
REQ-018 From FORBID with (1,1): next state SHALL be Q1 if FORBID_EXIT_Q=1, else Q0; forbid_exit=1 for exactly that cycle.
REQ-019 From FORBID with (0,1) or (1,0): normal set/reset; forbid_exit SHALL stay 0.
REQ-020 Latency: raw input change to output change SHALL be SYNC_STAGES+1 rising edges.
REQ-021 Q, Qbar, forbidden and forbid_exit SHALL be registered outputs with no combinational path from S or R.
REQ-022 Repeated identical requests (e.g. set held for many cycles) SHALL produce no output toggling.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force state Q0: Q=0, Qbar=1, forbidden=0, forbid_exit=0.
REQ-024 Reset SHALL load all synchronizer flops with 1 (hold), so no request is seen after reset release.
REQ-025 Reset SHALL override any input combination, including forbidden, and SHALL suppress forbid_exit.
REQ-026 The first request SHALL be evaluated at the first edge with rst_n=1.

Structure
REQ-027 Package sr_latch_pkg SHALL hold the state enum (ST_Q0, ST_Q1, ST_FORBID) and the SYNC_STAGES maximum constant (3).
REQ-028 One sub-module, sr_sync, SHALL implement the parameterized N-stage synchronizer with a reset value of 1; it SHALL be instantiated once per input.
REQ-029 The next-state logic and output decode SHALL reside in sr_latch_sync.

Verification
REQ-030 Reset then hold: rst_n=0 for 2 cycles, then S=1, R=1 for 5 cycles -> Q=0, Qbar=1, forbidden=0 throughout.
REQ-031 Set/hold/reset sequence (SYNC_STAGES=0), 5 cycles each: S,R = 11, 10, 11, 01, 11 -> Q = 0, 0, 0, 1, 1 (Qbar complementary), each change one edge after the input.
REQ-032 Forbidden then exit: S=0, R=0 for 5 cycles -> Q=1, Qbar=1, forbidden=1; then S=1, R=1 -> Q=0, Qbar=1, forbid_exit pulses exactly 1 cycle (Q=1 when FORBID_EXIT_Q=1).
REQ-033 Forbidden to set: S,R = 00 then 01 -> Q=1, Qbar=0, forbid_exit=0.
REQ-034 Reset during forbidden: S=0, R=0 with rst_n=0 -> next edge gives Q=0, Qbar=1, forbidden=0, and no forbid_exit pulse after release.
REQ-035 Latency with SYNC_STAGES=2: a set pulse of 1 cycle -> Q rises exactly 3 edges after the S falling edge.

Source files
------------

// File: rtl/sr_latch_pkg.sv
// Shared types for the synchronous SR latch: state encoding, output bundle, decode helper.
// Pure declarations; no latency or backpressure involved.
package sr_latch_pkg;

    typedef enum logic [1:0] {
        ST_Q0     = 2'd0,
        ST_Q1     = 2'd1,
        ST_FORBID = 2'd2
    } sr_state_e;

    localparam int SYNC_STAGES_MAX = 3;

    typedef struct packed {
        logic q;
        logic qbar;
        logic forbidden;
    } sr_out_t;

    function automatic sr_out_t decode_state(input sr_state_e st);
        sr_out_t o;
        o = '{q: 1'b0, qbar: 1'b1, forbidden: 1'b0};
        case (st)
            ST_Q1:     o = '{q: 1'b1, qbar: 1'b0, forbidden: 1'b0};
            ST_FORBID: o = '{q: 1'b1, qbar: 1'b1, forbidden: 1'b1};
            default:   o = '{q: 1'b0, qbar: 1'b1, forbidden: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sr_sync.sv
// N-stage input synchronizer, flops reset to 1 (the inactive level of an active-low request).
// Latency STAGES edges; STAGES=0 is a plain wire. No backpressure.
module sr_sync #(
    parameter int STAGES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_chain
            logic [STAGES-1:0] chain_q;
            logic [STAGES-1:0] chain_d;

            always_comb begin
                chain_d    = chain_q;
                chain_d[0] = d;
                for (int i = 1; i < STAGES; i++) begin
                    chain_d[i] = chain_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    chain_q <= '1;
                end else begin
                    chain_q <= chain_d;
                end
            end

            assign q = chain_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/sr_latch_sync.sv
// Clocked SR latch with active-low S/R, optional input synchronizers and forbidden-state tracking.
// Latency SYNC_STAGES+1 edges from raw input to registered outputs. No backpressure.
module sr_latch_sync
    import sr_latch_pkg::*;
#(
    parameter int   SYNC_STAGES   = 0,
    parameter logic FORBID_EXIT_Q = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic S,
    input  logic R,
    output logic Q,
    output logic Qbar,
    output logic forbidden,
    output logic forbid_exit
);

    localparam int STAGES_EFF = (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                                (SYNC_STAGES < 0) ? 0 : SYNC_STAGES;

    logic s_eff;
    logic r_eff;

    sr_sync #(.STAGES(STAGES_EFF)) u_sync_s (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (S),
        .q     (s_eff)
    );

    sr_sync #(.STAGES(STAGES_EFF)) u_sync_r (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (R),
        .q     (r_eff)
    );

    sr_state_e state_q;
    sr_state_e state_d;
    sr_out_t   out_q;
    sr_out_t   out_d;
    logic      forbid_exit_q;
    logic      forbid_exit_d;

    always_comb begin
        state_d       = state_q;
        forbid_exit_d = 1'b0;
        case ({s_eff, r_eff})
            2'b01:   state_d = ST_Q1;
            2'b10:   state_d = ST_Q0;
            2'b00:   state_d = ST_FORBID;
            default: begin
                // Releasing both requests at once leaves the latch undefined; pick FORBID_EXIT_Q.
                if (state_q == ST_FORBID) begin
                    state_d       = FORBID_EXIT_Q ? ST_Q1 : ST_Q0;
                    forbid_exit_d = 1'b1;
                end
            end
        endcase
        out_d = decode_state(state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_Q0;
            out_q         <= '{q: 1'b0, qbar: 1'b1, forbidden: 1'b0};
            forbid_exit_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_q         <= out_d;
            forbid_exit_q <= forbid_exit_d;
        end
    end

    assign Q           = out_q.q;
    assign Qbar        = out_q.qbar;
    assign forbidden   = out_q.forbidden;
    assign forbid_exit = forbid_exit_q;

endmodule

// File: tb/tb_sr_latch_sync.sv
// Directed bench for sr_latch_sync: one unsynchronized instance and one 2-stage instance exiting to Q=1.
module tb_sr_latch_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n0, s0, r0, q0, qb0, f0, fe0;
    logic rst_n2, s2, r2, q2, qb2, f2, fe2;

    int n_checks = 0;
    int n_fail   = 0;

    sr_latch_sync #(.SYNC_STAGES(0), .FORBID_EXIT_Q(1'b0)) dut0 (
        .clk (clk), .rst_n (rst_n0), .S (s0), .R (r0),
        .Q (q0), .Qbar (qb0), .forbidden (f0), .forbid_exit (fe0)
    );

    sr_latch_sync #(.SYNC_STAGES(2), .FORBID_EXIT_Q(1'b1)) dut2 (
        .clk (clk), .rst_n (rst_n2), .S (s2), .R (r2),
        .Q (q2), .Qbar (qb2), .forbidden (f2), .forbid_exit (fe2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (Q,Qbar,forbidden,forbid_exit)", tag, obs[3:0], exp[3:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [3:0] exp);
        check_eq(tag, {28'd0, q0, qb0, f0, fe0}, {28'd0, exp});
    endtask

    task automatic chk2(input string tag, input logic [3:0] exp);
        check_eq(tag, {28'd0, q2, qb2, f2, fe2}, {28'd0, exp});
    endtask

    initial begin
        rst_n0 = 1'b0; s0 = 1'b1; r0 = 1'b1;
        // dut2 sees a set request during reset; it must not survive reset release
        rst_n2 = 1'b0; s2 = 1'b0; r2 = 1'b1;
        repeat (2) tick();
        chk0("reset_state", 4'b0100);
        chk2("reset_state_sync2", 4'b0100);

        rst_n0 = 1'b1; rst_n2 = 1'b1; s2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk0("hold_after_reset", 4'b0100);
            chk2("sync_flops_reset_to_hold", 4'b0100);
        end

        s0 = 1'b1; r0 = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); chk0("reset_req", 4'b0100); end
        s0 = 1'b1; r0 = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); chk0("hold_q0", 4'b0100); end
        s0 = 1'b0; r0 = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); chk0("set_req", 4'b1000); end
        s0 = 1'b1; r0 = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); chk0("hold_q1", 4'b1000); end

        s0 = 1'b0; r0 = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); chk0("forbidden", 4'b1110); end
        s0 = 1'b1; r0 = 1'b1;
        tick(); chk0("forbid_exit_pulse", 4'b0101);
        tick(); chk0("forbid_exit_one_cycle", 4'b0100);
        tick(); chk0("forbid_exit_settled", 4'b0100);

        s0 = 1'b0; r0 = 1'b0;
        tick(); chk0("forbidden_before_set", 4'b1110);
        s0 = 1'b0; r0 = 1'b1;
        tick(); chk0("forbidden_to_set", 4'b1000);
        s0 = 1'b1; r0 = 1'b0;
        tick(); chk0("set_to_reset", 4'b0100);
        s0 = 1'b0; r0 = 1'b0;
        tick(); chk0("forbidden_to_reset_prep", 4'b1110);
        s0 = 1'b1; r0 = 1'b0;
        tick(); chk0("forbidden_to_reset", 4'b0100);

        s0 = 1'b0; r0 = 1'b0;
        tick(); chk0("forbidden_before_rst", 4'b1110);
        rst_n0 = 1'b0;
        tick(); chk0("reset_overrides_forbidden", 4'b0100);
        rst_n0 = 1'b1; s0 = 1'b1; r0 = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); chk0("no_exit_after_rst", 4'b0100); end

        s2 = 1'b0;
        tick(); chk2("set_lat_edge1", 4'b0100);
        s2 = 1'b1;
        tick(); chk2("set_lat_edge2", 4'b0100);
        tick(); chk2("set_lat_edge3", 4'b1000);
        tick(); chk2("set_pulse_held", 4'b1000);

        r2 = 1'b0;
        tick(); chk2("rst_lat_edge1", 4'b1000);
        r2 = 1'b1;
        tick(); chk2("rst_lat_edge2", 4'b1000);
        tick(); chk2("rst_lat_edge3", 4'b0100);

        s2 = 1'b0; r2 = 1'b0;
        tick();
        s2 = 1'b1; r2 = 1'b1;
        tick(); chk2("forbid_lat_edge2", 4'b0100);
        tick(); chk2("forbid_lat_edge3", 4'b1110);
        tick(); chk2("forbid_exit_to_q1", 4'b1001);
        tick(); chk2("forbid_exit_q1_settled", 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
